// File: rtl/pulse_stretcher_pkg.sv
// Shared types and constants for the pulse stretcher.
package pulse_stretcher_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int unsigned ZERO_COUNT = 0;

endpackage : pulse_stretcher_pkg

// File: rtl/pulse_stretcher.sv
// Turns single-cycle event pulses into a level held for a programmable number
// of cycles, plus a toggle output that flips on every sampled pulse.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 8,
    parameter bit          RETRIGGER   = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   pulse_in,
    input  logic [COUNT_WIDTH-1:0] length_in,
    input  logic                   cancel_in,
    output logic                   level_out,
    output logic                   toggle_out,
    output logic                   done_out,
    output logic                   dropped_out
);

    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_level;
    logic                   r_toggle;
    logic                   r_done;
    logic                   r_dropped;

    logic                   w_len_nonzero;
    logic                   w_count_zero;

    assign w_len_nonzero = (length_in != COUNT_WIDTH'(ZERO_COUNT));
    assign w_count_zero  = (r_count == COUNT_WIDTH'(ZERO_COUNT));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_level   <= 1'b0;
            r_toggle  <= 1'b0;
            r_done    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_dropped <= 1'b0;

            if (pulse_in) begin
                r_toggle <= ~r_toggle;
            end

            case (r_state)
                IDLE: begin
                    if (pulse_in && w_len_nonzero) begin
                        r_state <= ACTIVE;
                        r_level <= 1'b1;
                        r_count <= length_in - COUNT_WIDTH'(1);
                    end
                end

                ACTIVE: begin
                    if (cancel_in) begin
                        r_state <= IDLE;
                        r_level <= 1'b0;
                        r_count <= '0;
                    end else if (RETRIGGER && pulse_in && w_len_nonzero) begin
                        r_count <= length_in - COUNT_WIDTH'(1);
                    end else begin
                        // A rejected pulse still lets the stretch expire this cycle.
                        if (!RETRIGGER && pulse_in) begin
                            r_dropped <= 1'b1;
                        end
                        if (w_count_zero) begin
                            r_state <= IDLE;
                            r_level <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_count <= r_count - COUNT_WIDTH'(1);
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_level <= 1'b0;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign level_out   = r_level;
    assign toggle_out  = r_toggle;
    assign done_out    = r_done;
    assign dropped_out = r_dropped;

endmodule : pulse_stretcher

// File: tb/tb_pulse_stretcher.sv
// Directed bench: one instance without retrigger (A), one with retrigger (B).
module tb_pulse_stretcher;

    logic       clk;
    logic       rst_n;
    logic [7:0] length;
    logic       pulse_a, cancel_a, pulse_b, cancel_b;
    logic       lvl_a, tog_a, done_a, drop_a;
    logic       lvl_b, tog_b, done_b, drop_b;
    logic       exp_tog_a, exp_tog_b;
    int         n_tests, n_fail;
    int         n_high, n_done;

    pulse_stretcher #(.COUNT_WIDTH(8), .RETRIGGER(1'b0)) u_dut_a (
        .clock(clk), .reset_n(rst_n), .pulse_in(pulse_a), .length_in(length),
        .cancel_in(cancel_a), .level_out(lvl_a), .toggle_out(tog_a),
        .done_out(done_a), .dropped_out(drop_a)
    );

    pulse_stretcher #(.COUNT_WIDTH(8), .RETRIGGER(1'b1)) u_dut_b (
        .clock(clk), .reset_n(rst_n), .pulse_in(pulse_b), .length_in(length),
        .cancel_in(cancel_b), .level_out(lvl_b), .toggle_out(tog_b),
        .done_out(done_b), .dropped_out(drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (pulse_a) exp_tog_a = ~exp_tog_a;
            if (pulse_b) exp_tog_b = ~exp_tog_b;
        end
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic l, input logic d, input logic dr);
        chk({tag, ".a.level"},   int'(lvl_a),  int'(l));
        chk({tag, ".a.done"},    int'(done_a), int'(d));
        chk({tag, ".a.dropped"}, int'(drop_a), int'(dr));
        chk({tag, ".a.toggle"},  int'(tog_a),  int'(exp_tog_a));
    endtask

    task automatic chk_b(input string tag, input logic l, input logic d, input logic dr);
        chk({tag, ".b.level"},   int'(lvl_b),  int'(l));
        chk({tag, ".b.done"},    int'(done_b), int'(d));
        chk({tag, ".b.dropped"}, int'(drop_b), int'(dr));
        chk({tag, ".b.toggle"},  int'(tog_b),  int'(exp_tog_b));
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        exp_tog_a = 1'b0; exp_tog_b = 1'b0;
        rst_n = 1'b0; length = 8'd3;
        pulse_a = 1'b1; pulse_b = 1'b1; cancel_a = 1'b0; cancel_b = 1'b0;

        // Reset held with pulses present
        tick(); tick();
        chk_a("rst", 0, 0, 0);
        chk_b("rst", 0, 0, 0);
        pulse_a = 1'b0; pulse_b = 1'b0;
        rst_n = 1'b1;
        tick();
        chk_a("rst_rel", 0, 0, 0);

        // L=3 single pulse
        pulse_a = 1'b1; length = 8'd3; tick(); pulse_a = 1'b0;
        chk_a("l3.e0", 1, 0, 0);
        tick(); chk_a("l3.e1", 1, 0, 0);
        tick(); chk_a("l3.e2", 1, 0, 0);
        tick(); chk_a("l3.e3", 0, 1, 0);
        tick(); chk_a("l3.e4", 0, 0, 0);

        // L=1, then L=0
        pulse_a = 1'b1; length = 8'd1; tick(); pulse_a = 1'b0;
        chk_a("l1.e0", 1, 0, 0);
        tick(); chk_a("l1.e1", 0, 1, 0);
        tick(); chk_a("l1.e2", 0, 0, 0);
        pulse_a = 1'b1; length = 8'd0; tick(); pulse_a = 1'b0;
        chk_a("l0.e0", 0, 0, 0);
        tick(); chk_a("l0.e1", 0, 0, 0);

        // No retrigger: pulses at t0 and t2
        length = 8'd4;
        pulse_a = 1'b1; tick(); pulse_a = 1'b0; chk_a("nr.e0", 1, 0, 0);
        tick(); chk_a("nr.e1", 1, 0, 0);
        pulse_a = 1'b1; tick(); pulse_a = 1'b0; chk_a("nr.e2", 1, 0, 1);
        tick(); chk_a("nr.e3", 1, 0, 0);
        tick(); chk_a("nr.e4", 0, 1, 0);
        tick(); chk_a("nr.e5", 0, 0, 0);

        // No retrigger: pulse on the expiry edge
        pulse_a = 1'b1; tick(); pulse_a = 1'b0; chk_a("nrx.e0", 1, 0, 0);
        tick(); tick(); tick(); chk_a("nrx.e3", 1, 0, 0);
        pulse_a = 1'b1; tick(); pulse_a = 1'b0; chk_a("nrx.e4", 0, 1, 1);
        tick(); chk_a("nrx.e5", 0, 0, 0);

        // Cancel at cycle 3 of a 10-cycle stretch
        length = 8'd10;
        pulse_a = 1'b1; tick(); pulse_a = 1'b0; chk_a("can.e0", 1, 0, 0);
        tick(); tick();
        cancel_a = 1'b1; tick(); cancel_a = 1'b0; chk_a("can.e3", 0, 0, 0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_a || lvl_a) n_done++;
        end
        chk("can.quiet", n_done, 0);

        // Cancel with a coincident pulse
        pulse_a = 1'b1; tick(); pulse_a = 1'b0; chk_a("canp.e0", 1, 0, 0);
        tick();
        pulse_a = 1'b1; cancel_a = 1'b1; tick(); pulse_a = 1'b0; cancel_a = 1'b0;
        chk_a("canp.e2", 0, 0, 0);
        tick(); chk_a("canp.e3", 0, 0, 0);

        // Maximum length 255
        length = 8'd255;
        pulse_a = 1'b1; tick(); pulse_a = 1'b0;
        n_high = 0; n_done = 0;
        for (int i = 0; i < 300 && lvl_a; i++) begin
            if (done_a) n_done++;
            n_high++;
            tick();
            if (done_a) n_done++;
        end
        chk("max.high", n_high, 255);
        chk("max.done", n_done, 1);

        // Retrigger: pulses at t0 and t2, L=4
        length = 8'd4;
        pulse_b = 1'b1; tick(); pulse_b = 1'b0; chk_b("rt.e0", 1, 0, 0);
        tick(); chk_b("rt.e1", 1, 0, 0);
        pulse_b = 1'b1; tick(); pulse_b = 1'b0; chk_b("rt.e2", 1, 0, 0);
        n_high = 2; n_done = 0;
        for (int i = 0; i < 20 && lvl_b; i++) begin
            if (done_b) n_done++;
            n_high++;
            tick();
            if (done_b) n_done++;
        end
        chk("rt.high", n_high, 6);
        chk("rt.done", n_done, 1);
        tick();

        // Retrigger on the expiry edge
        pulse_b = 1'b1; tick(); pulse_b = 1'b0; chk_b("rtx.e0", 1, 0, 0);
        tick(); tick(); tick(); chk_b("rtx.e3", 1, 0, 0);
        pulse_b = 1'b1; tick(); pulse_b = 1'b0; chk_b("rtx.e4", 1, 0, 0);
        tick(); tick(); tick(); chk_b("rtx.e7", 1, 0, 0);
        tick(); chk_b("rtx.e8", 0, 1, 0);

        // Retrigger with L=0 while active does not reload
        length = 8'd2;
        pulse_b = 1'b1; tick(); chk_b("rt0.e0", 1, 0, 0);
        length = 8'd0; tick(); pulse_b = 1'b0; chk_b("rt0.e1", 1, 0, 0);
        tick(); chk_b("rt0.e2", 0, 1, 0);

        // Asynchronous reset mid-stretch
        length = 8'd20;
        pulse_a = 1'b1; tick(); pulse_a = 1'b0; chk_a("ar.e0", 1, 0, 0);
        tick(); tick();
        #2 rst_n = 1'b0;
        exp_tog_a = 1'b0; exp_tog_b = 1'b0;
        #1 chk_a("ar.async", 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done_a || lvl_a) n_done++;
        end
        chk("ar.quiet", n_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pulse_stretcher
